regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter width, default 32, register data width in bits.
REQ-002 Parameter total_reg, default 32, number of architectural registers.
REQ-003 Parameter address_reg, default $clog2(total_reg), register index width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 a_valid  input  1  requester A has a writeback.
REQ-007 a_ready  output  1  A queue can accept.
REQ-008 a_rd  input  address_reg  A destination index.
REQ-009 a_data  input  width  A writeback value.
REQ-010 b_valid, b_ready, b_rd, b_data  same directions and widths as A, for requester B.
REQ-011 wenable  output  1  write strobe to reg_file.
REQ-012 rd  output  address_reg  write index to reg_file.
REQ-013 rd_in  output  width  write data to reg_file.
REQ-014 q_rs1, q_rs2  input  address_reg  hazard query indices.
REQ-015 q_hit1, q_hit2  output  1  pending write to queried register.
REQ-016 empty  output  1  no writeback queued or on the output.

Function
REQ-017 Each requester SHALL have its own 2-entry FIFO of {rd, data}.
REQ-018 x_ready SHALL be 1 iff that FIFO holds fewer than 2 entries; it SHALL depend only on registered state, not on x_valid or a same-cycle pop.
REQ-019 A transfer SHALL occur on a rising edge where x_valid=1 and x_ready=1.
REQ-020 A transfer with x_rd=0 SHALL be accepted and discarded; it SHALL NOT be enqueued and SHALL never produce wenable.
REQ-021 Each cycle at most one FIFO head SHALL be granted and popped.
REQ-022 If exactly one FIFO is non-empty, it SHALL be granted, and the round-robin pointer SHALL then point to the other requester.
REQ-023 If both are non-empty, the requester named by the pointer SHALL be granted, and the pointer SHALL then flip.
REQ-024 If both are empty, there SHALL be no grant, and the pointer SHALL hold.
REQ-025 wenable, rd and rd_in SHALL be registered: after a grant edge, wenable=1 and rd/rd_in equal the granted head for exactly one cycle.
REQ-026 When no grant occurs, wenable SHALL be 0 and rd/rd_in SHALL hold their previous values.
REQ-027 Latency: a transfer at edge N into an empty, idle block SHALL drive wenable=1 after edge N+1; reg_file writes it at edge N+2.
REQ-028 A push and a pop on the same FIFO in one cycle SHALL both take effect; the occupancy is unchanged.
REQ-029 A FIFO entry pushed at edge N SHALL NOT be granted before edge N+1, so there is no bypass.
REQ-030 Per-requester order SHALL be preserved; cross-requester order SHALL follow the grant order.
REQ-031 q_hitK SHALL be combinational and SHALL be 1 iff q_rsK != 0 and q_rsK matches any valid entry in either FIFO, or matches rd while wenable=1.
REQ-032 empty SHALL be 1 iff both FIFOs are empty and wenable=0.
REQ-033 With continuous valid on both requesters, grants SHALL alternate A,B,A,B and each requester SHALL sustain 50% throughput.

Reset
REQ-034 While rst_n=0 at a rising edge, the block SHALL reset as follows:
- both FIFOs empty;
- pointer = A;
- wenable=0, rd=0, rd_in=0.
REQ-035 Reset values SHALL produce a_ready=1, b_ready=1 and empty=1 in the cycle after that edge.
REQ-036 Reset mid-operation SHALL discard all queued entries, and no wenable pulse SHALL follow for them.
REQ-037 Transfers presented during the reset edge SHALL NOT be accepted.

Verification
REQ-038 Single write: reset, then A pushes rd=3, data=100 -> wenable=1, rd=3, rd_in=100 for one cycle two edges later; empty returns to 1.
REQ-039 x0 drop: B pushes rd=0, data=200 -> no wenable pulse, empty stays 1, and q_hit1 with q_rs1=0 = 0.
REQ-040 Contention: A and B both valid for 4 cycles (A rd=1..4, B rd=5..8) -> write order is 1,5,2,6,3,7,4,8, and ready deasserts when a FIFO reaches 2 entries.
REQ-041 Hazard: A pushes rd=7 while B's FIFO is full -> q_rs2=7 gives q_hit2=1 until the cycle after the rd=7 wenable pulse, then 0.
REQ-042 Reset mid-flight: 3 entries queued, rst_n=0 for one edge -> no wenable pulses afterward, empty=1, and both ready=1.
REQ-043 Back-pressure: hold a_valid=1 with FIFO A full and B idle -> A drains one per cycle, and a_ready toggles so that accepted writes equal completed writes with no loss or duplication.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between two requesters, the register file write port and
// the hazard-query port of the writeback arbiter.
interface regfile_wb_arbiter_if #(
    parameter int width       = 32,
    parameter int total_reg   = 32,
    parameter int address_reg = $clog2(total_reg)
);
    logic                   a_valid;
    logic                   a_ready;
    logic [address_reg-1:0] a_rd;
    logic [width-1:0]       a_data;

    logic                   b_valid;
    logic                   b_ready;
    logic [address_reg-1:0] b_rd;
    logic [width-1:0]       b_data;

    logic                   wenable;
    logic [address_reg-1:0] rd;
    logic [width-1:0]       rd_in;

    logic [address_reg-1:0] q_rs1;
    logic [address_reg-1:0] q_rs2;
    logic                   q_hit1;
    logic                   q_hit2;

    logic                   empty;

    // Arbiter side
    modport slave (
        input  a_valid, a_rd, a_data,
        input  b_valid, b_rd, b_data,
        input  q_rs1, q_rs2,
        output a_ready, b_ready,
        output wenable, rd, rd_in,
        output q_hit1, q_hit2,
        output empty
    );

    // Requester / register-file side
    modport master (
        output a_valid, a_rd, a_data,
        output b_valid, b_rd, b_data,
        output q_rs1, q_rs2,
        input  a_ready, b_ready,
        input  wenable, rd, rd_in,
        input  q_hit1, q_hit2,
        input  empty
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter: each requester feeds a 2-entry FIFO,
// heads are granted round-robin into a registered register-file write port.
// Writes to x0 are accepted and dropped. Pending destinations can be queried
// combinationally for hazard detection.
module regfile_wb_arbiter #(
    parameter int width       = 32,
    parameter int total_reg   = 32,
    parameter int address_reg = $clog2(total_reg)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);

    typedef enum logic {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } ptr_t;

    ptr_t ptr;
    ptr_t ptr_next;

    // Per-requester FIFO state; index 0 is requester A, index 1 is B
    logic [1:0]             cnt      [2];
    logic                   wp       [2];
    logic                   rp       [2];
    logic [address_reg-1:0] mem_rd   [2][2];
    logic [width-1:0]       mem_data [2][2];

    logic                   in_valid [2];
    logic [address_reg-1:0] in_rd    [2];
    logic [width-1:0]       in_data  [2];
    logic                   ready    [2];
    logic                   nonempty [2];
    logic                   push     [2];
    logic                   pop      [2];
    logic                   vld      [2][2];

    logic                   grant_any;
    logic [address_reg-1:0] head_rd;
    logic [width-1:0]       head_data;

    logic                   wen_q;
    logic [address_reg-1:0] rd_q;
    logic [width-1:0]       data_q;

    logic                   hit1;
    logic                   hit2;

    // Gather requester inputs and derive ready/push/entry-valid from registered occupancy
    always_comb begin
        in_valid[0] = bus.a_valid;
        in_rd[0]    = bus.a_rd;
        in_data[0]  = bus.a_data;
        in_valid[1] = bus.b_valid;
        in_rd[1]    = bus.b_rd;
        in_data[1]  = bus.b_data;
        for (int unsigned r = 0; r < 2; r++) begin
            ready[r]    = (cnt[r] != 2'd2);
            nonempty[r] = (cnt[r] != 2'd0);
            // x0 writes complete the handshake but never enter the FIFO
            push[r]     = in_valid[r] && ready[r] && (in_rd[r] != '0);
            vld[r][0]   = (cnt[r] == 2'd2) || ((cnt[r] == 2'd1) && (rp[r] == 1'b0));
            vld[r][1]   = (cnt[r] == 2'd2) || ((cnt[r] == 2'd1) && (rp[r] == 1'b1));
        end
    end

    // Round-robin grant of at most one FIFO head per cycle
    always_comb begin
        ptr_next  = ptr;
        pop[0]    = 1'b0;
        pop[1]    = 1'b0;
        if (nonempty[0] && (!nonempty[1] || (ptr == PTR_A))) begin
            pop[0]   = 1'b1;
            ptr_next = PTR_B;
        end else if (nonempty[1]) begin
            pop[1]   = 1'b1;
            ptr_next = PTR_A;
        end
        grant_any = pop[0] || pop[1];
        if (pop[1]) begin
            head_rd   = mem_rd[1][rp[1]];
            head_data = mem_data[1][rp[1]];
        end else begin
            head_rd   = mem_rd[0][rp[0]];
            head_data = mem_data[0][rp[0]];
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= PTR_A;
        end else begin
            ptr <= ptr_next;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk) begin
        for (int unsigned r = 0; r < 2; r++) begin
            if (!rst_n) begin
                cnt[r] <= '0;
                wp[r]  <= 1'b0;
                rp[r]  <= 1'b0;
            end else begin
                if (push[r]) begin
                    wp[r] <= ~wp[r];
                end
                if (pop[r]) begin
                    rp[r] <= ~rp[r];
                end
                if (push[r] && !pop[r]) begin
                    cnt[r] <= cnt[r] + 2'd1;
                end else if (!push[r] && pop[r]) begin
                    cnt[r] <= cnt[r] - 2'd1;
                end
            end
        end
    end

    // FIFO storage; contents are only meaningful where the occupancy marks them valid
    always_ff @(posedge clk) begin
        for (int unsigned r = 0; r < 2; r++) begin
            if (push[r]) begin
                mem_rd[r][wp[r]]   <= in_rd[r];
                mem_data[r][wp[r]] <= in_data[r];
            end
        end
    end

    // Registered register-file write port; index/data hold when nothing is granted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wen_q  <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            wen_q <= grant_any;
            if (grant_any) begin
                rd_q   <= head_rd;
                data_q <= head_data;
            end
        end
    end

    // Hazard query against every queued entry and the write currently on the port
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int unsigned r = 0; r < 2; r++) begin
            for (int unsigned e = 0; e < 2; e++) begin
                if (vld[r][e] && (mem_rd[r][e] == bus.q_rs1)) begin
                    hit1 = 1'b1;
                end
                if (vld[r][e] && (mem_rd[r][e] == bus.q_rs2)) begin
                    hit2 = 1'b1;
                end
            end
        end
        if (wen_q && (rd_q == bus.q_rs1)) begin
            hit1 = 1'b1;
        end
        if (wen_q && (rd_q == bus.q_rs2)) begin
            hit2 = 1'b1;
        end
        if (bus.q_rs1 == '0) begin
            hit1 = 1'b0;
        end
        if (bus.q_rs2 == '0) begin
            hit2 = 1'b0;
        end
    end

    assign bus.a_ready = ready[0];
    assign bus.b_ready = ready[1];
    assign bus.wenable = wen_q;
    assign bus.rd      = rd_q;
    assign bus.rd_in   = data_q;
    assign bus.q_hit1  = hit1;
    assign bus.q_hit2  = hit2;
    assign bus.empty   = !nonempty[0] && !nonempty[1] && !wen_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios push their
// hand-computed write sequence into a queue; a negedge monitor pops and
// compares every wenable pulse.
module tb_regfile_wb_arbiter;
    localparam int W = 32;
    localparam int N = 32;
    localparam int A = $clog2(N);

    typedef struct packed {
        logic [A-1:0] rd;
        logic [W-1:0] data;
    } wb_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.width(W), .total_reg(N), .address_reg(A)) bus ();

    regfile_wb_arbiter #(.width(W), .total_reg(N), .address_reg(A)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    wb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  sa[$];
    int  sb[$];
    logic a_low;
    logic b_low;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_wb(input int rd, input int data);
        wb_t e;
        e.rd   = A'(rd);
        e.data = W'(data);
        exp_q.push_back(e);
    endtask

    task automatic set_a(input logic v, input int rd, input int data);
        bus.a_valid = v;
        bus.a_rd    = A'(rd);
        bus.a_data  = W'(data);
    endtask

    task automatic set_b(input logic v, input int rd, input int data);
        bus.b_valid = v;
        bus.b_rd    = A'(rd);
        bus.b_data  = W'(data);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_a(1'b0, 0, 0);
        set_b(1'b0, 0, 0);
        tick();
        rst_n = 1'b1;
    endtask

    // Wait for the scoreboard to empty, then let the final pulse retire
    task automatic drain(input string name);
        int budget = 30;
        while (exp_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        check({name, "_drained"}, W'(exp_q.size()), 0);
        tick();
        check({name, "_empty"}, W'(bus.empty), 1);
    endtask

    // Offer the sa/sb rd sequences (data = 1000 + rd), advancing on each accepted transfer
    task automatic run_stream(input string name);
        int   ia = 0;
        int   ib = 0;
        int   budget = 60;
        logic ar;
        logic br;
        a_low = 1'b0;
        b_low = 1'b0;
        while ((ia < sa.size() || ib < sb.size()) && budget > 0) begin
            if (ia < sa.size()) set_a(1'b1, sa[ia], 1000 + sa[ia]);
            else                set_a(1'b0, 0, 0);
            if (ib < sb.size()) set_b(1'b1, sb[ib], 1000 + sb[ib]);
            else                set_b(1'b0, 0, 0);
            ar = bus.a_ready;
            br = bus.b_ready;
            if (!ar) a_low = 1'b1;
            if (!br) b_low = 1'b1;
            tick();
            if (bus.a_valid && ar) ia++;
            if (bus.b_valid && br) ib++;
            budget--;
        end
        set_a(1'b0, 0, 0);
        set_b(1'b0, 0, 0);
        check({name, "_a_accepted"}, W'(ia), W'(sa.size()));
        check({name, "_b_accepted"}, W'(ib), W'(sb.size()));
    endtask

    // Monitor: every write pulse must match the next expected writeback
    always @(negedge clk) begin
        wb_t e;
        if (bus.wenable === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual rd=%0d data=%0d required=no write",
                         bus.rd, bus.rd_in);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (bus.rd !== e.rd || bus.rd_in !== e.data) begin
                    errors++;
                    $display("FAIL write_order actual rd=%0d data=%0d required rd=%0d data=%0d",
                             bus.rd, bus.rd_in, e.rd, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        bus.q_rs1 = '0;
        bus.q_rs2 = '0;
        set_a(1'b0, 0, 0);
        set_b(1'b0, 0, 0);
        @(negedge clk);
        tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_a_ready", W'(bus.a_ready), 1);
        check("rst_b_ready", W'(bus.b_ready), 1);
        check("rst_empty",   W'(bus.empty),   1);
        check("rst_wenable", W'(bus.wenable), 0);
        check("rst_rd",      W'(bus.rd),      0);
        check("rst_rd_in",   W'(bus.rd_in),   0);

        // Single write: rd=3 data=100
        expect_wb(3, 100);
        bus.q_rs1 = A'(3);
        set_a(1'b1, 3, 100);
        tick();
        set_a(1'b0, 0, 0);
        check("single_queued_empty", W'(bus.empty),  0);
        check("single_queued_hit1",  W'(bus.q_hit1), 1);
        tick();
        check("single_pulse_wenable", W'(bus.wenable), 1);
        tick();
        check("single_after_empty", W'(bus.empty),  1);
        check("single_after_hit1",  W'(bus.q_hit1), 0);

        // x0 drop from B
        bus.q_rs1 = '0;
        set_b(1'b1, 0, 200);
        tick();
        set_b(1'b0, 0, 0);
        check("x0_empty",   W'(bus.empty),   1);
        check("x0_hit1",    W'(bus.q_hit1),  0);
        check("x0_b_ready", W'(bus.b_ready), 1);
        tick();
        check("x0_empty_later", W'(bus.empty), 1);

        // Contention: order 1,5,2,6,3,7,4,8
        do_reset();
        expect_wb(1, 1001); expect_wb(5, 1005); expect_wb(2, 1002); expect_wb(6, 1006);
        expect_wb(3, 1003); expect_wb(7, 1007); expect_wb(4, 1004); expect_wb(8, 1008);
        sa = '{1, 2, 3, 4};
        sb = '{5, 6, 7, 8};
        run_stream("contend");
        check("contend_a_ready_low_seen", W'(a_low), 1);
        check("contend_b_ready_low_seen", W'(b_low), 1);
        drain("contend");

        // Hazard on rd=7 while B's FIFO is full
        do_reset();
        expect_wb(30, 300); expect_wb(20, 200); expect_wb(7, 70); expect_wb(21, 210);
        bus.q_rs2 = A'(7);
        set_a(1'b1, 30, 300);
        set_b(1'b1, 20, 200);
        tick();
        check("hazard_hit2_e1", W'(bus.q_hit2), 0);
        set_a(1'b1, 7, 70);
        set_b(1'b1, 21, 210);
        tick();
        set_a(1'b0, 0, 0);
        set_b(1'b0, 0, 0);
        check("hazard_b_full", W'(bus.b_ready), 0);
        check("hazard_hit2_e2", W'(bus.q_hit2), 1);
        tick();
        check("hazard_hit2_e3", W'(bus.q_hit2), 1);
        tick();
        check("hazard_wb7_rd",  W'(bus.rd),     7);
        check("hazard_hit2_e4", W'(bus.q_hit2), 1);
        tick();
        check("hazard_hit2_e5", W'(bus.q_hit2), 0);
        bus.q_rs2 = '0;
        drain("hazard");

        // Reset mid-flight with three entries queued; transfer during reset edge ignored
        do_reset();
        expect_wb(9, 900);
        set_a(1'b1, 9, 900);
        set_b(1'b1, 11, 1100);
        tick();
        set_a(1'b1, 10, 1000);
        set_b(1'b1, 12, 1200);
        tick();
        check("midrst_b_full", W'(bus.b_ready), 0);
        rst_n = 1'b0;
        set_a(1'b1, 13, 1300);
        set_b(1'b0, 0, 0);
        tick();
        rst_n = 1'b1;
        set_a(1'b0, 0, 0);
        bus.q_rs1 = A'(13);
        check("midrst_a_ready", W'(bus.a_ready), 1);
        check("midrst_b_ready", W'(bus.b_ready), 1);
        check("midrst_empty",   W'(bus.empty),   1);
        check("midrst_hit1",    W'(bus.q_hit1),  0);
        repeat (6) tick();
        check("midrst_empty_later", W'(bus.empty), 1);
        bus.q_rs1 = '0;

        // Back-pressure: A fills while B steals one grant, then drains in order
        do_reset();
        expect_wb(11, 1011); expect_wb(12, 1012); expect_wb(13, 1013); expect_wb(14, 1014);
        expect_wb(15, 1015); expect_wb(16, 1016); expect_wb(17, 1017);
        sa = '{11, 13, 14, 15, 16, 17};
        sb = '{12};
        run_stream("bp");
        check("bp_a_ready_low_seen", W'(a_low), 1);
        drain("bp");

        check("scoreboard_left", W'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
